// File: rtl/ldtu_dec_pkg.sv
// Shared codes, markers and word classes for the LiTe-DTU output word decoder.
package ldtu_dec_pkg;

    localparam logic [1:0]  CODE_BAS5 = 2'b01;
    localparam logic [1:0]  CODE_BASN = 2'b10;
    localparam logic [5:0]  CODE_SIG2 = 6'b001010;
    localparam logic [5:0]  CODE_SIG1 = 6'b001011;
    localparam logic [12:0] SYNC      = 13'h0AAA;
    localparam logic [12:0] HEADER    = 13'h1E0F;
    localparam logic [31:0] IDLE_WORD = 32'hF000_0000;

    typedef enum logic [2:0] {
        IDLE,
        BAS5,
        BASN,
        SIG2,
        SIG1,
        FB,
        BAD
    } word_class_t;

endpackage

// File: rtl/ldtu_dec_classify.sv
// Combinational classifier for one encoded word: class, sample count, orbit and parity flags.
// Fallback words are only decodable when LDTU_DEC_FALLBACK_EN is defined.
module ldtu_dec_classify
    import ldtu_dec_pkg::*;
(
    input  logic [31:0]  word,
    output word_class_t  cls,
    output logic [2:0]   count,
    output logic         orbit,
    output logic         par_err
);

    logic [5:0] basn_n;
    assign basn_n = word[29:24];

    always_comb begin
        cls     = BAD;
        count   = 3'd0;
        orbit   = 1'b0;
        par_err = 1'b0;
        if (word == IDLE_WORD) begin
            cls = IDLE;
        end else if (word[31:30] == CODE_BAS5) begin
            cls   = BAS5;
            count = 3'd5;
        end else if (word[31:30] == CODE_BASN) begin
            if (basn_n >= 6'd1 && basn_n <= 6'd4) begin
                cls   = BASN;
                count = basn_n[2:0];
            end
        end else if (word[31:26] == CODE_SIG2) begin
            cls   = SIG2;
            count = 3'd2;
        end else if (word[31:26] == CODE_SIG1) begin
            if (word[25:13] == SYNC) begin
                cls   = SIG1;
                count = 3'd1;
            end else if (word[25:13] == HEADER) begin
                cls   = SIG1;
                count = 3'd1;
                orbit = 1'b1;
            end
        end else if (word[31:28] == 4'hF) begin
`ifdef LDTU_DEC_FALLBACK_EN
            cls     = FB;
            count   = 3'd2;
            // Odd parity: each check bit makes its 13-bit half plus itself odd.
            par_err = (word[26] != ~^word[12:0]) | (word[27] != ~^word[25:13]);
`else
            cls = BAD;
`endif
        end
    end

endmodule

// File: rtl/ldtu_decoder.sv
// LiTe-DTU word stream decoder: unpacks accepted words into one 13-bit sample per cycle.
// Define LDTU_DEC_FALLBACK_EN to decode fallback words with parity checking.
module ldtu_decoder
    import ldtu_dec_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      word_in,
    input  logic             word_valid,
    output logic             word_ready,
    output logic [12:0]      sample_out,
    output logic             sample_valid,
    input  logic             sample_ready,
    output logic             sample_sig,
    output logic             sample_orbit,
    output logic             err_format,
    output logic             err_parity,
    output logic [CNT_W-1:0] err_count
);

    typedef enum logic [0:0] {S_IDLE, S_EMIT} state_t;

    state_t            state_q, state_d;
    logic [29:0]       shreg_q, shreg_d;
    logic [2:0]        remaining_q, remaining_d;
    logic              sig_q, sig_d;
    logic              orbit_q, orbit_d;
    logic              err_format_q, err_format_d;
    logic              err_parity_q, err_parity_d;
    logic [CNT_W-1:0]  err_count_q, err_count_d;

    word_class_t       cls;
    logic [2:0]        cls_count;
    logic              cls_orbit;
    logic              cls_par_err;

    logic              accept;
    logic              handshake;
    logic [1:0]        err_inc;
    logic [CNT_W:0]    err_sum;

    ldtu_dec_classify u_classify (
        .word    (word_in),
        .cls     (cls),
        .count   (cls_count),
        .orbit   (cls_orbit),
        .par_err (cls_par_err)
    );

    assign word_ready   = (state_q == S_IDLE) | ((remaining_q == 3'd1) & sample_ready);
    assign sample_valid = (state_q == S_EMIT);
    assign accept       = word_valid & word_ready;
    assign handshake    = sample_valid & sample_ready;

    assign sample_out   = sig_q ? shreg_q[12:0] : {7'd0, shreg_q[5:0]};
    assign sample_sig   = sig_q;
    assign sample_orbit = orbit_q;
    assign err_format   = err_format_q;
    assign err_parity   = err_parity_q;
    assign err_count    = err_count_q;

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        remaining_d = remaining_q;
        sig_d       = sig_q;
        orbit_d     = orbit_q;

        if (handshake) begin
            shreg_d     = sig_q ? (shreg_q >> 13) : (shreg_q >> 6);
            remaining_d = remaining_q - 3'd1;
            if (remaining_q == 3'd1) begin
                state_d = S_IDLE;
            end
        end

        // A new word may only be accepted when the current one is finishing, so it wins.
        if (accept && cls_count != 3'd0) begin
            state_d     = S_EMIT;
            shreg_d     = word_in[29:0];
            remaining_d = cls_count;
            sig_d       = (cls == SIG2) | (cls == SIG1) | (cls == FB);
            orbit_d     = cls_orbit;
        end
    end

    always_comb begin
        err_format_d = accept & (cls == BAD);
        err_parity_d = accept & (cls == FB) & cls_par_err;
        err_inc      = {1'b0, err_format_d} + {1'b0, err_parity_d};
        err_sum      = {1'b0, err_count_q} + {{(CNT_W - 1){1'b0}}, err_inc};
        err_count_d  = err_sum[CNT_W] ? {CNT_W{1'b1}} : err_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            shreg_q      <= '0;
            remaining_q  <= '0;
            sig_q        <= 1'b0;
            orbit_q      <= 1'b0;
            err_format_q <= 1'b0;
            err_parity_q <= 1'b0;
            err_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            remaining_q  <= remaining_d;
            sig_q        <= sig_d;
            orbit_q      <= orbit_d;
            err_format_q <= err_format_d;
            err_parity_q <= err_parity_d;
            err_count_q  <= err_count_d;
        end
    end

endmodule

// File: tb/tb_ldtu_decoder.sv
// Scoreboard bench for ldtu_decoder: directed words queue expected samples, a monitor checks them.
module tb_ldtu_decoder;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] word_in = '0;
    logic        word_valid = 1'b0;
    logic        word_ready;
    logic [12:0] sample_out;
    logic        sample_valid;
    logic        sample_ready = 1'b1;
    logic        sample_sig;
    logic        sample_orbit;
    logic        err_format;
    logic        err_parity;
    logic [15:0] err_count;

    int total = 0;
    int bad = 0;
    // {sig, orbit, sample}
    logic [14:0] exp_q[$];

    ldtu_decoder #(.CNT_W(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .word_in      (word_in),
        .word_valid   (word_valid),
        .word_ready   (word_ready),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .sample_sig   (sample_sig),
        .sample_orbit (sample_orbit),
        .err_format   (err_format),
        .err_parity   (err_parity),
        .err_count    (err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset && sample_valid && sample_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_sample: got %0h expected none", sample_out);
            end else begin
                logic [14:0] e;
                e = exp_q.pop_front();
                if ({sample_sig, sample_orbit, sample_out} !== e) begin
                    bad++;
                    $display("FAIL sample: got sig=%0b orbit=%0b out=%0h expected sig=%0b orbit=%0b out=%0h",
                             sample_sig, sample_orbit, sample_out, e[14], e[13], e[12:0]);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] w, output int waits);
        waits = 0;
        word_in = w;
        word_valid = 1'b1;
        while (!word_ready && waits < 50) begin
            cyc();
            waits++;
        end
        if (!word_ready) begin
            total++;
            bad++;
            $display("FAIL send_timeout: got word_ready=0 expected 1");
        end
        cyc();
        word_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            cyc();
            n++;
        end
        chk("drain_left", 32'(exp_q.size()), 32'd0);
        cyc();
    endtask

    task automatic push(input logic sig, input logic orbit, input logic [12:0] s);
        exp_q.push_back({sig, orbit, s});
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_word_ready"}, 32'(word_ready), 32'd1);
        chk({tag, "_sample_valid"}, 32'(sample_valid), 32'd0);
        chk({tag, "_sample_out"}, 32'(sample_out), 32'd0);
        chk({tag, "_sample_sig"}, 32'(sample_sig), 32'd0);
        chk({tag, "_sample_orbit"}, 32'(sample_orbit), 32'd0);
        chk({tag, "_err_format"}, 32'(err_format), 32'd0);
        chk({tag, "_err_parity"}, 32'(err_parity), 32'd0);
        chk({tag, "_err_count"}, 32'(err_count), 32'd0);
    endtask

    initial begin
        int w;
        repeat (3) cyc();
        chk_reset_values("reset");
        reset = 1'b1;
        cyc();

        // BAS5: 1..5 on consecutive cycles.
        for (int i = 1; i <= 5; i++) push(1'b0, 1'b0, 13'(i));
        send({2'b01, 6'd5, 6'd4, 6'd3, 6'd2, 6'd1}, w);
        chk("bas5_first", 32'(sample_out), 32'd1);
        chk("bas5_busy_ready", 32'(word_ready), 32'd0);
        for (int i = 0; i < 5; i++) begin
            chk("bas5_valid_run", 32'(sample_valid), 32'd1);
            cyc();
        end
        chk("bas5_done", 32'(sample_valid), 32'd0);
        drain();

        // BASN n=2 then SIG2 back-to-back.
        push(1'b0, 1'b0, 13'd7);
        push(1'b0, 1'b0, 13'd9);
        push(1'b1, 1'b0, 13'h1ABC);
        push(1'b1, 1'b0, 13'h0123);
        send({2'b10, 6'd2, 12'd0, 6'd9, 6'd7}, w);
        send({6'b001010, 13'h0123, 13'h1ABC}, w);
        chk("b2b_waits", 32'(w), 32'd1);
        chk("b2b_no_gap", 32'(sample_out), 32'h1ABC);
        drain();

        // SIG1 header, then IDLE word.
        push(1'b1, 1'b1, 13'h0055);
        send({6'b001011, 13'h1E0F, 13'h0055}, w);
        chk("sig1_orbit", 32'(sample_orbit), 32'd1);
        send(32'hF000_0000, w);
        chk("idle_no_sample", 32'(sample_valid), 32'd0);
        cyc();
        chk("idle_no_sample2", 32'(sample_valid), 32'd0);
        chk("idle_no_err", 32'(err_format), 32'd0);
        drain();

        // Format errors.
        send({2'b10, 6'd0, 24'd0}, w);
        chk("basn0_err", 32'(err_format), 32'd1);
        chk("basn0_nosample", 32'(sample_valid), 32'd0);
        send({6'b001011, 13'h0001, 13'h0000}, w);
        chk("sig1bad_err", 32'(err_format), 32'd1);
        chk("sig1bad_nosample", 32'(sample_valid), 32'd0);
        chk("err_count2", 32'(err_count), 32'd2);
        cyc();
        chk("err_pulse_end", 32'(err_format), 32'd0);

        // Fallback word with wrong [26] (correct would be [27]=1, [26]=0).
`ifdef LDTU_DEC_FALLBACK_EN
        push(1'b1, 1'b0, 13'h0001);
        push(1'b1, 1'b0, 13'h0003);
        send({4'b1111, 1'b1, 1'b1, 13'h0003, 13'h0001}, w);
        chk("fb_parity", 32'(err_parity), 32'd1);
        chk("fb_no_format", 32'(err_format), 32'd0);
        chk("fb_valid", 32'(sample_valid), 32'd1);
`else
        send({4'b1111, 1'b1, 1'b1, 13'h0003, 13'h0001}, w);
        chk("fb_format", 32'(err_format), 32'd1);
        chk("fb_no_parity", 32'(err_parity), 32'd0);
        chk("fb_nosample", 32'(sample_valid), 32'd0);
`endif
        chk("err_count3", 32'(err_count), 32'd3);
        drain();

        // Stall mid-BAS5, then reset mid-word.
        for (int i = 21; i <= 25; i++) push(1'b0, 1'b0, 13'(i));
        send({2'b01, 6'd25, 6'd24, 6'd23, 6'd22, 6'd21}, w);
        cyc();
        sample_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("stall_valid", 32'(sample_valid), 32'd1);
            chk("stall_hold", 32'(sample_out), 32'd22);
            chk("stall_ready", 32'(word_ready), 32'd0);
            if (i < 2) cyc();
        end
        reset = 1'b0;
        cyc();
        chk_reset_values("midreset");
        exp_q.delete();
        reset = 1'b1;
        sample_ready = 1'b1;
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ldtu_decoder.md
# ldtu_decoder

Back-end decoder for the LiTe-DTU 32-bit output word stream. It accepts encoded words (baseline, signal, idle, and optionally fallback), unpacks them into a one-sample-per-cycle stream of 13-bit samples, and flags format and parity errors. It sits on the receiving end of the DTU link, after word alignment, and feeds the off-detector sample reconstruction and monitoring logic.

## Interface
- `CNT_W`, default 16: width of the saturating error counter.
- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-low.
- `word_in`  in  32  encoded word.
- `word_valid`  in  1  `word_in` is valid.
- `word_ready`  out  1  decoder accepts `word_in` this cycle.
- `sample_out`  out  13  decoded sample; baseline samples are zero-extended from 6 bits.
- `sample_valid`  out  1  `sample_out` is valid.
- `sample_ready`  in  1  downstream accepts the sample.
- `sample_sig`  out  1  1 = signal or fallback sample, 0 = baseline sample.
- `sample_orbit`  out  1  the sample came from a header (orbit) word.
- `err_format`  out  1  one-cycle pulse: the accepted word was undecodable.
- `err_parity`  out  1  one-cycle pulse: fallback parity mismatch.
- `err_count`  out  CNT_W  saturating count of `err_format` plus `err_parity` events.

## Operation
- A word is accepted when `word_valid` and `word_ready` are both high.
- Word classes, checked in this order:
  - IDLE: `32'hF000_0000`. Consumed; produces no samples.
  - BAS5: `[31:30]=01`. Five 6-bit samples, taken from the low bits upward: `[5:0]`, then `[11:6]`, and so on.
  - BASN: `[31:30]=10`, with `n=[29:24]`.
    - n in 1..4: emit n 6-bit samples from the low bits upward.
    - Any other n (including 0 and 5..63): `err_format`, word dropped.
  - SIG2: `[31:26]=001010`. Emit `[12:0]`, then `[25:13]`.
  - SIG1: `[31:26]=001011`, with the marker in `[25:13]`.
    - Marker `13'h0AAA` (sync): emit `[12:0]`.
    - Marker `13'h1E0F` (header): emit `[12:0]` with `sample_orbit=1`.
    - Any other marker: `err_format`, word dropped.
  - FB: `[31:28]=1111`, not IDLE. Handling depends on `LDTU_DEC_FALLBACK_EN` (see Configuration).
  - Anything else: `err_format`, word dropped.
- State machine:
  - States: `S_IDLE` and `S_EMIT`.
  - `S_IDLE -> S_EMIT` when a word with at least one sample is accepted. The word is loaded into a shift register, `remaining` is set to the sample count, and the class flags are latched.
  - In `S_EMIT`, each handshake (`sample_valid & sample_ready`) shifts the register right by 6 (baseline) or 13 (signal) and decrements `remaining`.
  - On the last handshake: if a new word is accepted in the same cycle, reload and stay in `S_EMIT`; otherwise go to `S_IDLE`.
- `word_ready = (state==S_IDLE) | (remaining==1 & sample_ready)`.
- `sample_valid = (state==S_EMIT)`. `sample_out`, `sample_sig` and `sample_orbit` are held stable while `sample_ready=0`.
- `err_count` increments by 1 for each error pulse and saturates at all-ones. A word that raises both errors in one cycle counts 2, saturating.

## Timing
- Reset values: `word_ready=1`, `sample_valid=0`, `sample_out=0`, `sample_sig=0`, `sample_orbit=0`, `err_format=0`, `err_parity=0`, `err_count=0`, state `S_IDLE`.
- Latency: a word accepted in cycle N has its first sample valid in cycle N+1.
- Error pulses assert in cycle N+1.
- Throughput: one sample per cycle with `sample_ready` tied high. Back-to-back words produce no bubble.
- Reset mid-word: the partially emitted word is discarded, and the next cycle shows reset values.
- Words rejected by `err_format` consume one accept cycle and produce no samples.

## Configuration
- `LDTU_DEC_FALLBACK_EN` defined:
  - FB words emit `[12:0]` (odd sample), then `[25:13]` (even sample), with `sample_sig=1`.
  - Parity is checked: `[26]` must equal `~^[12:0]` and `[27]` must equal `~^[25:13]`.
  - On mismatch, `err_parity` pulses and the samples are still emitted.
- `LDTU_DEC_FALLBACK_EN` undefined:
  - FB words raise `err_format` and are dropped.
  - `err_parity` is tied to 0.

## Structure
- Package `ldtu_dec_pkg` holds:
  - Constants: `CODE_BAS5=2'b01`, `CODE_BASN=2'b10`, `CODE_SIG2=6'b001010`, `CODE_SIG1=6'b001011`, `SYNC=13'h0AAA`, `HEADER=13'h1E0F`, `IDLE_WORD=32'hF000_0000`.
  - Enum `word_class_t` with values IDLE, BAS5, BASN, SIG2, SIG1, FB, BAD.
- One sub-module, `ldtu_dec_classify`:
  - Purely combinational.
  - Inputs: the word.
  - Outputs: class, sample count, orbit flag, parity-error flag.
- The FSM, shift register and error counter live in the top module.

## Test plan
- BAS5 word `{2'b01,6'd5,6'd4,6'd3,6'd2,6'd1}`, `sample_ready=1` -> samples 1,2,3,4,5 on 5 consecutive cycles, `sample_sig=0`.
- BASN word with n=2, samples 7 then 9, followed back-to-back by SIG2 word `{6'b001010,13'h0123,13'h1ABC}` -> 7, 9, `13'h1ABC`, `13'h0123` with no gap. `word_ready` is high during the last sample of the first word.
- SIG1 header word `{6'b001011,13'h1E0F,13'h0055}` -> one sample `13'h0055` with `sample_orbit=1`. Then IDLE word -> no sample.
- BASN with n=0, then SIG1 with marker `13'h0001` -> two `err_format` pulses, no samples, `err_count=2`.
- FB word with bad `[26]`, macro defined -> two samples plus `err_parity`. With the macro undefined -> `err_format` and no samples.
- `sample_ready=0` for 3 cycles mid-BAS5, then reset asserted mid-word -> outputs held during the stall, then reset values in the next cycle.
